// File: rtl/if_stage_if.sv
// Fetch-stage bundle: the IM address/data pair, pipeline control from decode/execute,
// and the IF/ID register outputs.
interface if_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) ();
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_data;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc_plus;
    logic               ifid_valid;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        input  stall, flush, branch_taken, branch_target, im_data,
        output im_addr, ifid_instr, ifid_pc_plus, ifid_valid, halted, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, im_data,
        input  im_addr, ifid_instr, ifid_pc_plus, ifid_valid, halted, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, redirect/flush/stall handling, fetch counter.
// Optional HALT state (opcode 4'hF) is built only when IF_HALT_EN is defined.
//
// state | meaning
// RUN   | fetching normally; stall/flush/branch act on PC and IF/ID
// HALT  | halt instruction fetched; PC frozen, IF/ID bubbles, only branch_taken resumes
module if_stage #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_plus_q, pc_plus_d;
    logic               valid_q, valid_d;
    logic [15:0]        count_q, count_d;
    logic [ADDR_W-1:0]  pc_seq;
    logic               in_halt;
    logic               halt_fetch;

`ifdef IF_HALT_EN
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_halt    = (state_q == HALT);
    assign halt_fetch = (bus.im_data[INSTR_W-1 -: 4] == 4'hF);

    always_comb begin
        state_d = state_q;
        if (bus.branch_taken) begin
            state_d = RUN;
        end else if (state_q == RUN && !bus.flush && !bus.stall && halt_fetch) begin
            state_d = HALT;
        end
    end
`else
    assign in_halt    = 1'b0;
    assign halt_fetch = 1'b0;
`endif

    assign pc_seq = pc_q + STEP;

    // Priority: redirect > halt freeze > flush > stall > advance.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_plus_d = pc_plus_q;
        valid_d   = valid_q;
        count_d   = count_q;
        if (bus.branch_taken) begin
            pc_d      = bus.branch_target;
            instr_d   = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (in_halt) begin
            instr_d   = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (bus.flush) begin
            pc_d      = pc_seq;
            instr_d   = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (!bus.stall) begin
            pc_d      = pc_seq;
            instr_d   = bus.im_data;
            pc_plus_d = pc_seq;
            valid_d   = 1'b1;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_plus_q <= pc_plus_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign bus.im_addr      = pc_q;
    assign bus.ifid_instr   = instr_q;
    assign bus.ifid_pc_plus = pc_plus_q;
    assign bus.ifid_valid   = valid_q;
    assign bus.fetch_count  = count_q;
    assign bus.halted       = in_halt;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; IM is modelled as IM[a] = {4'h0, a[11:0]}
// with an optional halt opcode (16'hF000) planted at halt_addr.
module tb_if_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic        halt_on;
    logic [15:0] halt_addr;

    if_stage_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    if_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.im_data = (halt_on && bus.im_addr == halt_addr) ? 16'hF000
                                                               : {4'h0, bus.im_addr[11:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IF_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        halt_on = 1'b0;
        do_reset();
        checks++; if (bus.im_addr !== 16'h0000) begin errors++; $display("FAIL reset_im_addr got %h exp 0000", bus.im_addr); end
        checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", bus.ifid_instr); end
        checks++; if (bus.ifid_pc_plus !== 16'h0000) begin errors++; $display("FAIL reset_pc_plus got %h exp 0000", bus.ifid_pc_plus); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
        checks++; if (bus.fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.fetch_count); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            step();
            checks++; if (bus.ifid_instr !== 16'(n - 1)) begin errors++; $display("FAIL run_instr n=%0d got %h exp %h", n, bus.ifid_instr, 16'(n - 1)); end
            checks++; if (bus.ifid_pc_plus !== 16'(n)) begin errors++; $display("FAIL run_pc_plus n=%0d got %h exp %h", n, bus.ifid_pc_plus, 16'(n)); end
            checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL run_valid n=%0d got %b exp 1", n, bus.ifid_valid); end
            checks++; if (bus.fetch_count !== 16'(n)) begin errors++; $display("FAIL run_count n=%0d got %0d exp %0d", n, bus.fetch_count, n); end
            checks++; if (bus.im_addr !== 16'(n)) begin errors++; $display("FAIL run_im_addr n=%0d got %h exp %h", n, bus.im_addr, 16'(n)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) step();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.im_addr !== 16'h0004) begin errors++; $display("FAIL stall_im_addr k=%0d got %h exp 0004", k, bus.im_addr); end
            checks++; if (bus.ifid_instr !== 16'h0003) begin errors++; $display("FAIL stall_instr k=%0d got %h exp 0003", k, bus.ifid_instr); end
            checks++; if (bus.fetch_count !== 16'd4) begin errors++; $display("FAIL stall_count k=%0d got %0d exp 4", k, bus.fetch_count); end
        end
        bus.stall = 1'b0;
        step();
        checks++; if (bus.ifid_instr !== 16'h0004) begin errors++; $display("FAIL stall_release_instr got %h exp 0004", bus.ifid_instr); end
        checks++; if (bus.ifid_pc_plus !== 16'h0005) begin errors++; $display("FAIL stall_release_pc_plus got %h exp 0005", bus.ifid_pc_plus); end
        checks++; if (bus.fetch_count !== 16'd5) begin errors++; $display("FAIL stall_release_count got %0d exp 5", bus.fetch_count); end
    endtask

    // Continues from test_stall: PC=5, count=5.
    task automatic test_branch();
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        step();
        idle_inputs();
        checks++; if (bus.im_addr !== 16'h0040) begin errors++; $display("FAIL branch_im_addr got %h exp 0040", bus.im_addr); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL branch_bubble_instr got %h exp 0000", bus.ifid_instr); end
        checks++; if (bus.fetch_count !== 16'd5) begin errors++; $display("FAIL branch_count got %0d exp 5", bus.fetch_count); end
        step();
        checks++; if (bus.ifid_instr !== 16'h0040) begin errors++; $display("FAIL branch_target_instr got %h exp 0040", bus.ifid_instr); end
        checks++; if (bus.ifid_pc_plus !== 16'h0041) begin errors++; $display("FAIL branch_target_pc_plus got %h exp 0041", bus.ifid_pc_plus); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL branch_target_valid got %b exp 1", bus.ifid_valid); end
        checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL branch_target_count got %0d exp 6", bus.fetch_count); end
    endtask

    // Continues from test_branch: PC=0x41, count=6.
    task automatic test_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.im_addr !== 16'h0042) begin errors++; $display("FAIL flush_im_addr got %h exp 0042", bus.im_addr); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL flush_count got %0d exp 6", bus.fetch_count); end
        step();
        checks++; if (bus.ifid_instr !== 16'h0042) begin errors++; $display("FAIL flush_next_instr got %h exp 0042", bus.ifid_instr); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b exp 1", bus.ifid_valid); end
    endtask

    task automatic test_wrap();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'hFFFF;
        step();
        idle_inputs();
        checks++; if (bus.im_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset_im_addr got %h exp ffff", bus.im_addr); end
        step();
        checks++; if (bus.ifid_instr !== 16'h0FFF) begin errors++; $display("FAIL wrap_instr got %h exp 0fff", bus.ifid_instr); end
        checks++; if (bus.ifid_pc_plus !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus got %h exp 0000", bus.ifid_pc_plus); end
        checks++; if (bus.im_addr !== 16'h0000) begin errors++; $display("FAIL wrap_im_addr got %h exp 0000", bus.im_addr); end
    endtask

    task automatic test_halt();
        halt_on   = 1'b1;
        halt_addr = 16'h0005;
        do_reset();
        repeat (6) step();
        checks++; if (bus.ifid_instr !== 16'hF000) begin errors++; $display("FAIL halt_load_instr got %h exp f000", bus.ifid_instr); end
        checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_load_valid got %b exp 1", bus.ifid_valid); end
        checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL halt_load_count got %0d exp 6", bus.fetch_count); end
        checks++; if (bus.halted !== HALT_EN) begin errors++; $display("FAIL halt_flag got %b exp %b", bus.halted, HALT_EN); end
        checks++; if (bus.im_addr !== 16'h0006) begin errors++; $display("FAIL halt_im_addr got %h exp 0006", bus.im_addr); end
        if (HALT_EN) begin
            bus.stall = 1'b1;
            repeat (2) step();
            bus.stall = 1'b0;
            checks++; if (bus.im_addr !== 16'h0006) begin errors++; $display("FAIL halt_frozen_im_addr got %h exp 0006", bus.im_addr); end
            checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble_valid got %b exp 0", bus.ifid_valid); end
            checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold got %b exp 1", bus.halted); end
            checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL halt_hold_count got %0d exp 6", bus.fetch_count); end
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flush_exit got %b exp 1", bus.halted); end
            checks++; if (bus.im_addr !== 16'h0006) begin errors++; $display("FAIL halt_flush_im_addr got %h exp 0006", bus.im_addr); end
            bus.branch_taken  = 1'b1;
            bus.branch_target = 16'h0010;
            step();
            idle_inputs();
            checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_exit got %b exp 0", bus.halted); end
            checks++; if (bus.im_addr !== 16'h0010) begin errors++; $display("FAIL halt_exit_im_addr got %h exp 0010", bus.im_addr); end
            step();
            checks++; if (bus.ifid_instr !== 16'h0010) begin errors++; $display("FAIL halt_resume_instr got %h exp 0010", bus.ifid_instr); end
            checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_resume_valid got %b exp 1", bus.ifid_valid); end
        end else begin
            step();
            checks++; if (bus.ifid_instr !== 16'h0006) begin errors++; $display("FAIL nohalt_instr6 got %h exp 0006", bus.ifid_instr); end
            checks++; if (bus.im_addr !== 16'h0007) begin errors++; $display("FAIL nohalt_im_addr got %h exp 0007", bus.im_addr); end
            step();
            checks++; if (bus.ifid_instr !== 16'h0007) begin errors++; $display("FAIL nohalt_instr7 got %h exp 0007", bus.ifid_instr); end
            checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL nohalt_flag got %b exp 0", bus.halted); end
        end
    endtask

    task automatic test_reset_mid();
        halt_on   = 1'b1;
        halt_addr = 16'd19;
        do_reset();
        repeat (20) step();
        checks++; if (bus.fetch_count !== 16'd20) begin errors++; $display("FAIL pre_reset_count got %0d exp 20", bus.fetch_count); end
        checks++; if (bus.halted !== HALT_EN) begin errors++; $display("FAIL pre_reset_halted got %b exp %b", bus.halted, HALT_EN); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        halt_on = 1'b0;
        checks++; if (bus.im_addr !== 16'h0000) begin errors++; $display("FAIL mid_reset_im_addr got %h exp 0000", bus.im_addr); end
        checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL mid_reset_instr got %h exp 0000", bus.ifid_instr); end
        checks++; if (bus.ifid_pc_plus !== 16'h0000) begin errors++; $display("FAIL mid_reset_pc_plus got %h exp 0000", bus.ifid_pc_plus); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", bus.ifid_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL mid_reset_halted got %b exp 0", bus.halted); end
        checks++; if (bus.fetch_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", bus.fetch_count); end
        step();
        checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL post_reset_fetch got valid=%b instr=%h exp valid=1 instr=0000", bus.ifid_valid, bus.ifid_instr); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        halt_on   = 1'b0;
        halt_addr = 16'h0000;
        idle_inputs();
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
